// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath: memory sizing, reset PC
// and the opcode/funct decode constants used by the control unit.
package mips_mc_pkg;

  localparam int unsigned DEF_MEM_WORDS = 64;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef logic [5:0]  word_idx_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/unified_mem.sv
// Unified instruction/data memory: combinational read, synchronous write,
// preload port with priority over datapath stores.
module unified_mem
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  word_idx_t addr_i,
  input  logic      we_i,
  input  word_t     wdata_i,
  input  logic      prog_we_i,
  input  word_idx_t prog_addr_i,
  input  word_t     prog_data_i,
  output word_t     rdata_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Word indices wrap modulo the array depth, so odd depths still alias cleanly.
  function automatic logic [IDX_W-1:0] wrapIdx(input word_idx_t w);
    return IDX_W'(32'(w) % MEM_WORDS);
  endfunction

  word_t            mem_q [MEM_WORDS];
  logic [IDX_W-1:0] rwIdx;
  logic [IDX_W-1:0] progIdx;

  assign rwIdx   = wrapIdx(addr_i);
  assign progIdx = wrapIdx(prog_addr_i);
  assign rdata_o = mem_q[rwIdx];

  // Contents survive reset; only the datapath store is suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) begin
      mem_q[progIdx] <= prog_data_i;
    end else if (we_i && !rst_i) begin
      mem_q[rwIdx] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_mem_unit.sv
// Fetch/memory stage of the multicycle MIPS: PC, instruction register, memory
// data register and fetch counter around the unified memory.
module fetch_mem_unit
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        PCSrc,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  input  logic        prog_we,
  input  logic [5:0]  prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] Data,
  output logic [31:0] instr_count
);

  word_t     pc_q, pc_d;
  word_t     instr_q, instr_d;
  word_t     data_q;
  word_t     count_q, count_d;
  word_t     adr;
  word_t     rd;
  word_idx_t memIdx;
  logic      pcEn;
  logic      unusedAdrBits;

  assign adr           = IorD ? ALUOut : pc_q;
  assign memIdx        = adr[7:2];
  assign unusedAdrBits = ^{adr[31:8], adr[1:0]};

  unified_mem #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (memIdx),
    .we_i        (MemWrite),
    .wdata_i     (WriteData),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data),
    .rdata_o     (rd)
  );

  always_comb begin
    pcEn    = PCWrite | (Branch & Zero);
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    if (pcEn) begin
      pc_d = PCSrc ? ALUOut : ALUResult;
    end
    if (IRWrite) begin
      instr_d = rd;
      count_d = count_q + 32'd1;
    end
  end

  // Reset wins over every strobe, abandoning any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= rd;
      count_q <= count_d;
    end
  end

  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign Data        = data_q;
  assign instr_count = count_q;

endmodule

// File: doc/fetch_mem_unit.md
FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

Interface
REQ-001 Parameter MEM_WORDS, default 64, SHALL set the unified instruction/data memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset, synchronous and active-high.
REQ-005 Ports IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, input, 1 each: control strobes from Control_Unit, with their usual multicycle meaning.
REQ-006 Port Zero, input, 1: ALU zero flag.
REQ-007 Port ALUResult, input, 32: unregistered ALU output, used for PC+4.
REQ-008 Port ALUOut, input, 32: registered ALU output, used as the data address and the branch target.
REQ-009 Port WriteData, input, 32: store data (register B).
REQ-010 Ports prog_we, input, 1; prog_addr, input, 6; prog_data, input, 32: program preload write port, word-addressed.
REQ-011 Port PC, output, 32: current program counter.
REQ-012 Port Instr, output, 32: instruction register contents.
REQ-013 Ports Opcode, output, 6, and Funct, output, 6: Instr[31:26] and Instr[5:0], returned to Control_Unit.
REQ-014 Port Data, output, 32: memory data register (MDR).
REQ-015 Port instr_count, output, 32: number of instruction fetches since reset.

Function
REQ-016 Adr SHALL be ALUOut when IorD=1, else PC; word index = Adr[7:2]; Adr[1:0] and bits above 7 SHALL be ignored (index wraps modulo MEM_WORDS).
REQ-017 Memory read SHALL be combinational: RD = mem[index].
REQ-018 PCEn SHALL be PCWrite | (Branch & Zero); when PCEn=1, PC SHALL load ALUOut if PCSrc=1, else ALUResult.
REQ-019 When IRWrite=1, Instr SHALL load RD at the edge; otherwise it holds.
REQ-020 Data SHALL load RD on every non-reset edge (one-cycle latency from Adr).
REQ-021 When MemWrite=1, mem[index] SHALL be written with WriteData at the edge.
REQ-022 Read-during-write: RD, Instr and Data SHALL capture the pre-write word in that cycle; the new word is visible from the next cycle.
REQ-023 When prog_we=1, mem[prog_addr] SHALL be written with prog_data; prog_we SHALL be honoured during reset as well.
REQ-024 When prog_we and MemWrite are both 1, prog_we SHALL take priority and the MemWrite SHALL be dropped.
REQ-025 instr_count SHALL increment by 1 on each edge with IRWrite=1 and wrap from 32'hFFFF_FFFF to 0.
REQ-026 Opcode and Funct SHALL be pure slices of Instr, with no added latency.

Reset
REQ-027 When rst=1 at an edge: PC=RESET_PC, Instr=0, Data=0, instr_count=0; Opcode and Funct are therefore 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset SHALL override PCEn, IRWrite and MemWrite in the same cycle; reset mid-instruction SHALL abandon that instruction.

Structure
REQ-030 Shared package mips_mc_pkg SHALL hold MEM_WORDS and RESET_PC defaults plus the opcode/funct constants (R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, ADDI 6'h08).
REQ-031 The memory array with its read/write/priority logic SHALL be a sub-module unified_mem; PC, IR, MDR and the counter SHALL stay in fetch_mem_unit.

Verification
REQ-032 Preload mem[0]=32'h8C01_0004 via prog_we, deassert rst, IRWrite=1, PCWrite=1, ALUResult=4 -> next cycle Instr=32'h8C01_0004, Opcode=6'h23, PC=4, instr_count=1.
REQ-033 IorD=1, ALUOut=32'h10, mem[4]=32'hDEAD_BEEF -> Data=32'hDEAD_BEEF one cycle later; Instr unchanged.
REQ-034 MemWrite=1, IorD=1, ALUOut=32'h20, WriteData=32'h1234_5678 -> Data holds the old mem[8] that cycle and 32'h1234_5678 the following cycle.
REQ-035 Branch=1, PCSrc=1, ALUOut=32'h40: with Zero=0 -> PC unchanged; with Zero=1 -> PC=32'h40.
REQ-036 prog_we=1 (prog_addr=2, prog_data=32'hAAAA_AAAA) together with MemWrite=1 at index 2 (WriteData=32'h5555_5555) -> mem[2]=32'hAAAA_AAAA.
REQ-037 Assert rst mid-sequence with PC=32'h40 and instr_count=5 -> next cycle PC=0, Instr=0, Data=0, instr_count=0, and previously written memory words still intact.
